// File: rtl/adder_pkg.sv
// ============================================================================
// adder_pkg : shared width default and {carry,sum} reference helper
// Rev 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

  localparam int DEFAULT_ADDER_W = 4;

  // Returns {carry, sum}: bit 64 is the carry out of bit w-1, bits [63:0] the
  // sum truncated to w bits. Operands are expected to fit in w bits (1..64).
  function automatic logic [64:0] ref_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic        ci,
                                          input int unsigned w);
    logic [64:0] full;
    logic [64:0] mask;
    logic [64:0] res;
    full = {1'b0, a} + {1'b0, b} + {64'd0, ci};
    mask = (65'd1 << w) - 65'd1;
    res = full & mask;
    res[64] = full[w];
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rca_full_adder.sv
// ============================================================================
// rca_full_adder : single-bit full adder cell for the ripple chain
// Rev 1.0
// ============================================================================
`default_nettype none

module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);

endmodule

`default_nettype wire

// File: rtl/ripple_carry_adder.sv
// ============================================================================
// ripple_carry_adder : N-bit ripple-carry add-with-carry, registered result
// Rev 1.0
// ============================================================================
`default_nettype none

module ripple_carry_adder
  import adder_pkg::*;
#(
  parameter int N = DEFAULT_ADDER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         out_valid
);

  logic [N:0]   w_c;
  logic [N-1:0] w_sum;
  logic [N-1:0] r_sum;
  logic         r_cout;
  logic         r_out_valid;

  assign w_c[0] = Cin;

  // Unpipelined carry chain: bit i waits on the carry from bit i-1.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      rca_full_adder u_fa (
        .a  (A[gi]),
        .b  (B[gi]),
        .ci (w_c[gi]),
        .s  (w_sum[gi]),
        .co (w_c[gi+1])
      );
    end
  endgenerate

  // Capture only on valid so idle-cycle operands (possibly X) never reach the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_c[N];
      end
    end
  end

  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_ripple_carry_adder.sv
// ============================================================================
// tb_ripple_carry_adder : vector table, corner sequences and random sweep
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ripple_carry_adder;
  import adder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=4 instance
  logic       iv4, ci4, co4, ov4;
  logic [3:0] a4, b4, s4;
  // N=8 instance
  logic       iv8, ci8, co8, ov8;
  logic [7:0] a8, b8, s8;
  // N=1 instance
  logic       iv1, ci1, co1, ov1;
  logic [0:0] a1, b1, s1;

  ripple_carry_adder #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .A(a4), .B(b4), .Cin(ci4),
    .Sum(s4), .Cout(co4), .out_valid(ov4));
  ripple_carry_adder #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .A(a8), .B(b8), .Cin(ci8),
    .Sum(s8), .Cout(co8), .out_valid(ov8));
  ripple_carry_adder #(.N(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .A(a1), .B(b1), .Cin(ci1),
    .Sum(s1), .Cout(co1), .out_valid(ov1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       iv;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] exp_sum;
    logic       exp_cout;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[8];

  logic [64:0] r;
  logic [7:0]  e8_sum;
  logic        e8_cout;
  logic [0:0]  e1_sum;
  logic        e1_cout;

  initial begin
    vecs[0] = '{1'b1, 4'd10, 4'd1,  1'b0, 4'd11, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 4'd15, 4'd15, 1'b0, 4'd14, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 4'd10, 4'd5,  1'b0, 4'd15, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 4'd15, 4'd0,  1'b1, 4'd0,  1'b1, 1'b1};
    vecs[4] = '{1'b1, 4'd7,  4'd9,  1'b1, 4'd1,  1'b1, 1'b1};
    vecs[5] = '{1'b0, 4'd3,  4'd3,  1'b0, 4'd1,  1'b1, 1'b0};
    vecs[6] = '{1'b1, 4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b1};
    vecs[7] = '{1'b1, 4'd8,  4'd8,  1'b1, 4'd1,  1'b1, 1'b1};

    rst = 1'b1;
    iv4 = 0; a4 = 0; b4 = 0; ci4 = 0;
    iv8 = 0; a8 = 0; b8 = 0; ci8 = 0;
    iv1 = 0; a1 = 0; b1 = 0; ci1 = 0;
    #3;
    chk("reset_sum4", 64'(s4), 0);
    chk("reset_cout4", 64'(co4), 0);
    chk("reset_ov4", 64'(ov4), 0);
    chk("reset_ov8", 64'(ov8), 0);
    chk("reset_ov1", 64'(ov1), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_release_ov4", 64'(ov4), 0);

    // Table: consecutive valid entries double as the back-to-back test.
    for (int i = 0; i < 8; i++) begin
      iv4 = vecs[i].iv; a4 = vecs[i].a; b4 = vecs[i].b; ci4 = vecs[i].ci;
      tick();
      chk($sformatf("vec%0d_sum", i), 64'(s4), 64'(vecs[i].exp_sum));
      chk($sformatf("vec%0d_cout", i), 64'(co4), 64'(vecs[i].exp_cout));
      chk($sformatf("vec%0d_ov", i), 64'(ov4), 64'(vecs[i].exp_ov));
    end

    // Idle cycles with unknown operands must hold the last result.
    iv4 = 0; a4 = 'x; b4 = 'x; ci4 = 1'bx;
    tick();
    tick();
    chk("xhold_sum", 64'(s4), 1);
    chk("xhold_cout", 64'(co4), 1);
    chk("xhold_ov", 64'(ov4), 0);

    // Reset mid-stream, asserted between edges.
    iv4 = 1; a4 = 4'd9; b4 = 4'd9; ci4 = 0;
    tick();
    chk("pre_rst_sum", 64'(s4), 2);
    chk("pre_rst_cout", 64'(co4), 1);
    chk("pre_rst_ov", 64'(ov4), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sum", 64'(s4), 0);
    chk("midrst_cout", 64'(co4), 0);
    chk("midrst_ov", 64'(ov4), 0);
    iv4 = 0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rel_sum", 64'(s4), 0);
    chk("rel_ov", 64'(ov4), 0);
    tick();
    chk("rel2_cout", 64'(co4), 0);
    chk("rel2_ov", 64'(ov4), 0);
    iv4 = 1; a4 = 4'd6; b4 = 4'd5; ci4 = 1;
    tick();
    chk("first_after_rel_sum", 64'(s4), 12);
    chk("first_after_rel_ov", 64'(ov4), 1);
    iv4 = 0;

    // Random sweep on N=8 and N=1 against plain arithmetic.
    e8_sum = 0; e8_cout = 0; e1_sum = 0; e1_cout = 0;
    for (int i = 0; i < 1000; i++) begin
      iv8 = ($urandom_range(3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      iv1 = ($urandom_range(3) != 0);
      a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
      if (iv8) begin
        r = ref_add(64'(a8), 64'(b8), ci8, 8);
        e8_sum = r[7:0]; e8_cout = r[64];
      end
      if (iv1) begin
        r = ref_add(64'(a1), 64'(b1), ci1, 1);
        e1_sum = r[0:0]; e1_cout = r[64];
      end
      tick();
      chk("rand8_sum", 64'(s8), 64'(e8_sum));
      chk("rand8_cout", 64'(co8), 64'(e8_cout));
      chk("rand8_ov", 64'(ov8), 64'(iv8));
      chk("rand1_sum", 64'(s1), 64'(e1_sum));
      chk("rand1_cout", 64'(co1), 64'(e1_cout));
      chk("rand1_ov", 64'(ov1), 64'(iv1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
